decode_regfile: RTL and testbench

- Decode stage of the Y86-64 processor, directly downstream of fetch.
- Holds the 15-entry × 64-bit program register file (IDs 0x0–0xE; 0xF = none).
- Selects source and destination registers per icode and reads valA/valB.
- Accepts up to two write-back writes per cycle and registers its results into the decode→execute pipeline register, with stall/bubble control.

---
 rtl/decode_regfile.sv | 119 +++++++++++
 tb/tb_decode_regfile.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_regfile.sv
// Y86-64 decode stage: 15x64 register file, operand selection/read and the D->E pipeline register.
// Optional macro DECODE_WB_BYPASS_EN makes reads see same-cycle write-back data (M over E).
module decode_regfile #(
  parameter logic [3:0] RSP_ID    = 4'h4,
  parameter logic [3:0] NOP_ICODE = 4'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [3:0]  d_icode,
  input  logic [3:0]  d_ifun,
  input  logic [3:0]  d_rA,
  input  logic [3:0]  d_rB,
  input  logic [63:0] d_valC,
  input  logic [63:0] d_valP,
  input  logic        stall,
  input  logic        bubble,
  input  logic [3:0]  w_dstE,
  input  logic [63:0] w_valE,
  input  logic [3:0]  w_dstM,
  input  logic [63:0] w_valM,
  output logic        e_valid,
  output logic [3:0]  e_icode,
  output logic [3:0]  e_ifun,
  output logic [63:0] e_valC,
  output logic [63:0] e_valA,
  output logic [63:0] e_valB,
  output logic [3:0]  e_srcA,
  output logic [3:0]  e_srcB,
  output logic [3:0]  e_dstE,
  output logic [3:0]  e_dstM
);
  localparam logic [3:0] RNONE = 4'hF;

  logic [63:0] r_regs [15];
  logic [3:0]  w_src_a, w_src_b, w_dst_e, w_dst_m;
  logic [63:0] w_rd_a, w_rd_b, w_val_a;

  // M port is applied after E so it wins when both target the same register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 15; i++) begin
      if (reset) begin
        r_regs[i] <= '0;
      end else if (w_dstM == 4'(i)) begin
        r_regs[i] <= w_valM;
      end else if (w_dstE == 4'(i)) begin
        r_regs[i] <= w_valE;
      end
    end
  end

  always_comb begin
    w_src_a = RNONE;
    w_src_b = RNONE;
    w_dst_e = RNONE;
    w_dst_m = RNONE;
    case (d_icode)
      4'h2: begin w_src_a = d_rA; w_dst_e = d_rB; end
      4'h3: begin w_dst_e = d_rB; end
      4'h4: begin w_src_a = d_rA; w_src_b = d_rB; end
      4'h5: begin w_src_b = d_rB; w_dst_m = d_rA; end
      4'h6: begin w_src_a = d_rA; w_src_b = d_rB; w_dst_e = d_rB; end
      4'h8: begin w_src_b = RSP_ID; w_dst_e = RSP_ID; end
      4'h9: begin w_src_a = RSP_ID; w_src_b = RSP_ID; w_dst_e = RSP_ID; end
      4'hA: begin w_src_a = d_rA; w_src_b = RSP_ID; w_dst_e = RSP_ID; end
      4'hB: begin w_src_a = RSP_ID; w_src_b = RSP_ID; w_dst_e = RSP_ID; w_dst_m = d_rA; end
      default: ;
    endcase
  end

  // ID 0xF matches no entry, so it reads as zero.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int i = 0; i < 15; i++) begin
      if (w_src_a == 4'(i)) w_rd_a = r_regs[i];
      if (w_src_b == 4'(i)) w_rd_b = r_regs[i];
    end
`ifdef DECODE_WB_BYPASS_EN
    if (w_src_a != RNONE) begin
      if (w_src_a == w_dstM)      w_rd_a = w_valM;
      else if (w_src_a == w_dstE) w_rd_a = w_valE;
    end
    if (w_src_b != RNONE) begin
      if (w_src_b == w_dstM)      w_rd_b = w_valM;
      else if (w_src_b == w_dstE) w_rd_b = w_valE;
    end
`endif
  end

  assign w_val_a = (d_icode == 4'h7 || d_icode == 4'h8) ? d_valP : w_rd_a;

  // Priority: reset, bubble, stall (hold), empty input (NOP), load.
  always_ff @(posedge clk) begin
    if (reset || bubble || (!stall && !d_valid)) begin
      e_valid <= 1'b0;
      e_icode <= NOP_ICODE;
      e_ifun  <= '0;
      e_valC  <= '0;
      e_valA  <= '0;
      e_valB  <= '0;
      e_srcA  <= RNONE;
      e_srcB  <= RNONE;
      e_dstE  <= RNONE;
      e_dstM  <= RNONE;
    end else if (!stall) begin
      e_valid <= 1'b1;
      e_icode <= d_icode;
      e_ifun  <= d_ifun;
      e_valC  <= d_valC;
      e_valA  <= w_val_a;
      e_valB  <= w_rd_b;
      e_srcA  <= w_src_a;
      e_srcB  <= w_src_b;
      e_dstE  <= w_dst_e;
      e_dstM  <= w_dst_m;
    end
  end
endmodule

// File: tb/tb_decode_regfile.sv
// Scoreboard bench for decode_regfile: driver pushes model-predicted E state, monitor pops and compares.
module tb_decode_regfile;
  localparam logic [3:0] RSP = 4'h4;
  localparam logic [3:0] NONE = 4'hF;

  logic        clk = 1'b0;
  logic        reset, d_valid, stall, bubble;
  logic [3:0]  d_icode, d_ifun, d_rA, d_rB, w_dstE, w_dstM;
  logic [63:0] d_valC, d_valP, w_valE, w_valM;
  logic        e_valid;
  logic [3:0]  e_icode, e_ifun, e_srcA, e_srcB, e_dstE, e_dstM;
  logic [63:0] e_valC, e_valA, e_valB;

  typedef struct packed {
    logic        valid;
    logic [3:0]  icode, ifun;
    logic [63:0] valC, valA, valB;
    logic [3:0]  srcA, srcB, dstE, dstM;
  } e_t;

  e_t          exp_q[$];
  e_t          m_e;
  logic [63:0] m_rf [15];
  int          errors = 0;
  int          checks = 0;
  int          txn = 0;

  decode_regfile #(.RSP_ID(RSP), .NOP_ICODE(4'h1)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_rA(d_rA), .d_rB(d_rB), .d_valC(d_valC), .d_valP(d_valP), .stall(stall),
    .bubble(bubble), .w_dstE(w_dstE), .w_valE(w_valE), .w_dstM(w_dstM), .w_valM(w_valM),
    .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun), .e_valC(e_valC),
    .e_valA(e_valA), .e_valB(e_valB), .e_srcA(e_srcA), .e_srcB(e_srcB),
    .e_dstE(e_dstE), .e_dstM(e_dstM)
  );

  always #5 clk = ~clk;

  function automatic e_t nop_e();
    e_t n;
    n = '{valid: 1'b0, icode: 4'h1, ifun: 4'h0, valC: 64'h0, valA: 64'h0, valB: 64'h0,
          srcA: NONE, srcB: NONE, dstE: NONE, dstM: NONE};
    return n;
  endfunction

  // Register read as seen by decode in the current cycle.
  function automatic logic [63:0] m_read(input logic [3:0] id);
    if (id == NONE) return 64'h0;
`ifdef DECODE_WB_BYPASS_EN
    if (id == w_dstM) return w_valM;
    if (id == w_dstE) return w_valE;
`endif
    return m_rf[id];
  endfunction

  // Reference step for one clock edge: predict E, update model, push expectation.
  task automatic step();
    e_t d;
    int ic;
    ic = int'(d_icode);
    d = nop_e();
    d.valid = 1'b1;
    d.icode = d_icode;
    d.ifun  = d_ifun;
    d.valC  = d_valC;
    if (ic inside {2, 4, 6, 10}) d.srcA = d_rA;
    else if (ic inside {9, 11})  d.srcA = RSP;
    if (ic inside {4, 5, 6})             d.srcB = d_rB;
    else if (ic inside {8, 9, 10, 11})   d.srcB = RSP;
    if (ic inside {2, 3, 6})             d.dstE = d_rB;
    else if (ic inside {8, 9, 10, 11})   d.dstE = RSP;
    if (ic inside {5, 11})               d.dstM = d_rA;
    d.valA = (ic == 7 || ic == 8) ? d_valP : m_read(d.srcA);
    d.valB = m_read(d.srcB);
    if (reset) begin
      m_e = nop_e();
      for (int i = 0; i < 15; i++) m_rf[i] = 64'h0;
    end else begin
      if (bubble)        m_e = nop_e();
      else if (stall)    m_e = m_e;
      else if (!d_valid) m_e = nop_e();
      else               m_e = d;
      if (w_dstE != NONE) m_rf[w_dstE] = w_valE;
      if (w_dstM != NONE) m_rf[w_dstM] = w_valM;
    end
    exp_q.push_back(m_e);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic idle_in();
    reset = 0; d_valid = 0; stall = 0; bubble = 0;
    d_icode = 4'h1; d_ifun = 0; d_rA = NONE; d_rB = NONE; d_valC = 0; d_valP = 0;
    w_dstE = NONE; w_valE = 0; w_dstM = NONE; w_valM = 0;
  endtask

  task automatic dec(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                     input logic [63:0] vc, input logic [63:0] vp);
    d_valid = 1; d_icode = ic; d_ifun = 4'h0; d_rA = ra; d_rB = rb; d_valC = vc; d_valP = vp;
  endtask

  // Monitor: compares the E register one time unit after every rising edge.
  initial begin
    e_t act, want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        act = '{valid: e_valid, icode: e_icode, ifun: e_ifun, valC: e_valC, valA: e_valA,
                valB: e_valB, srcA: e_srcA, srcB: e_srcB, dstE: e_dstE, dstM: e_dstM};
        checks++;
        txn++;
        if (act !== want) begin
          errors++;
          $display("FAIL txn%0d e_reg: got v=%b ic=%h A=%h B=%h sA=%h sB=%h dE=%h dM=%h want v=%b ic=%h A=%h B=%h sA=%h sB=%h dE=%h dM=%h",
                   txn, act.valid, act.icode, act.valA, act.valB, act.srcA, act.srcB, act.dstE, act.dstM,
                   want.valid, want.icode, want.valA, want.valB, want.srcA, want.srcB, want.dstE, want.dstM);
        end else begin
          $display("txn%0d ok v=%b ic=%h A=%h B=%h", txn, act.valid, act.icode, act.valA, act.valB);
        end
      end
    end
  end

  initial begin
    idle_in();
    reset = 1;
    m_e = nop_e();
    for (int i = 0; i < 15; i++) m_rf[i] = 64'h0;
    @(negedge clk);
    step(); step();
    reset = 0;
    step();
    chk("idle_valid", 64'(e_valid), 64'h0);
    chk("idle_icode", 64'(e_icode), 64'h1);
    chk("idle_srcA", 64'(e_srcA), 64'hF);
    chk("idle_dstM", 64'(e_dstM), 64'hF);
    chk("idle_valB", e_valB, 64'h0);

    w_dstE = 4'h3; w_valE = 64'h1122334455667788;
    step();
    idle_in(); dec(4'h6, 4'h3, 4'h3, 64'h0, 64'h0);
    step();
    chk("opq_valA", e_valA, 64'h1122334455667788);
    chk("opq_valB", e_valB, 64'h1122334455667788);
    chk("opq_dstE", 64'(e_dstE), 64'h3);

    idle_in(); w_dstE = 4'h4; w_valE = 64'h10; w_dstM = 4'h4; w_valM = 64'h20;
    step();
    idle_in(); dec(4'hA, 4'h4, NONE, 64'h0, 64'h0);
    step();
    chk("push_valB", e_valB, 64'h20);
    chk("push_srcB", 64'(e_srcB), 64'h4);
    chk("push_dstE", 64'(e_dstE), 64'h4);

    idle_in(); dec(4'h8, NONE, NONE, 64'h100, 64'h40);
    step();
    chk("call_valA", e_valA, 64'h40);
    chk("call_srcB", 64'(e_srcB), 64'h4);
    chk("call_dstM", 64'(e_dstM), 64'hF);

    idle_in(); dec(4'h5, 4'h1, 4'h3, 64'h8, 64'h0);
    step();
    for (int k = 0; k < 3; k++) begin
      stall = 1; dec(4'(k + 2), 4'(k), 4'(k + 1), 64'(k + 100), 64'(k));
      step();
      chk("stall_valC", e_valC, 64'h8);
      chk("stall_icode", 64'(e_icode), 64'h5);
    end
    stall = 1; bubble = 1;
    step();
    chk("stbub_valid", 64'(e_valid), 64'h0);
    chk("stbub_icode", 64'(e_icode), 64'h1);

    idle_in(); w_dstE = 4'h7; w_valE = 64'h77;
    step();
    idle_in(); w_dstE = 4'h7; w_valE = 64'h55; dec(4'h2, 4'h7, 4'h2, 64'h0, 64'h0);
    step();
`ifdef DECODE_WB_BYPASS_EN
    chk("rrmov_valA", e_valA, 64'h55);
`else
    chk("rrmov_valA", e_valA, 64'h77);
`endif

    idle_in(); dec(4'hC, 4'h1, 4'h2, 64'h0, 64'h0);
    step();
    chk("inv_valid", 64'(e_valid), 64'h1);
    chk("inv_srcA", 64'(e_srcA), 64'hF);
    chk("inv_dstE", 64'(e_dstE), 64'hF);

    for (int n = 0; n < 300; n++) begin
      reset   = ($urandom_range(0, 63) == 0);
      stall   = ($urandom_range(0, 5) == 0);
      bubble  = ($urandom_range(0, 9) == 0);
      d_valid = ($urandom_range(0, 3) != 0);
      d_icode = 4'($urandom_range(0, 15));
      d_ifun  = 4'($urandom_range(0, 15));
      d_rA    = 4'($urandom_range(0, 15));
      d_rB    = 4'($urandom_range(0, 15));
      d_valC  = {$urandom, $urandom};
      d_valP  = {$urandom, $urandom};
      w_dstE  = ($urandom_range(0, 3) == 0) ? NONE : 4'($urandom_range(0, 14));
      w_dstM  = ($urandom_range(0, 2) == 0) ? NONE : 4'($urandom_range(0, 14));
      w_valE  = {$urandom, $urandom};
      w_valM  = {$urandom, $urandom};
      step();
    end

    idle_in();
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
